fb_frame_scheduler: RTL

Sequences each frame's use of the single framebuffer write port in the double-buffered renderer. On each frame start, it first clears the draw bank to a programmable color. It then grants the port to the upstream pixel writer until that writer signals render-done, and swaps draw and display banks at the next frame start. It sits between the pixel-address generator and the framebuffer BRAM write port.

---
 rtl/fb_frame_scheduler.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/fb_frame_scheduler.sv
// Framebuffer write-port scheduler for a double-buffered renderer.
// Each frame: clear the draw bank to a latched color, then hand the port to
// the pixel writer until render-done, then wait for the next frame start to
// swap draw/display banks and begin the next clear.
module fb_frame_scheduler #(
  parameter int unsigned H_RES = 320,
  parameter int unsigned V_RES = 180
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        frame_start_in,
  input  logic [15:0] clear_color_in,
  input  logic        pix_valid_in,
  input  logic [15:0] pix_addr_in,
  input  logic [15:0] pix_color_in,
  output logic        pix_ready_out,
  input  logic        render_done_in,
  output logic        wr_en_out,
  output logic [15:0] wr_addr_out,
  output logic [15:0] wr_data_out,
  output logic        wr_bank_out,
  output logic        disp_bank_out,
  output logic        busy_out,
  output logic        oob_out,
  output logic        overrun_out
);

  localparam int unsigned NumPix = H_RES * V_RES;
  // Last clear address; NumPix may be exactly 65536, so it stays 16 bits.
  localparam logic [15:0] LastAddr = 16'(NumPix - 1);
  // Range limit kept at 17 bits so a full 64K frame compares correctly.
  localparam logic [16:0] PixLimit = 17'(NumPix);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StClear  = 2'd1,
    StRender = 2'd2,
    StDone   = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] color_q, color_d;
  logic        draw_bank_q, draw_bank_d;
  logic        wr_en_q, wr_en_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        oob_q, oob_d;
  logic        overrun_q, overrun_d;

  logic        clear_last;
  logic        pix_fire;
  logic        pix_in_range;

  assign clear_last   = (cnt_q == LastAddr);
  assign pix_fire     = pix_valid_in && (state_q == StRender);
  assign pix_in_range = ({1'b0, pix_addr_in} < PixLimit);

  // State register plus all datapath flops; reset drops any in-flight write.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      color_q     <= '0;
      draw_bank_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      oob_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      color_q     <= color_d;
      draw_bank_q <= draw_bank_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      oob_q       <= oob_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next-state sequencing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (frame_start_in) state_d = StClear;
      end
      StClear: begin
        if (clear_last) state_d = StRender;
      end
      StRender: begin
        if (render_done_in) state_d = StDone;
      end
      StDone: begin
        if (frame_start_in) state_d = StClear;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: clear counter, color latch, bank swap, write port, flags.
  always_comb begin
    cnt_d       = cnt_q;
    color_d     = color_q;
    draw_bank_d = draw_bank_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    oob_d       = oob_q;
    overrun_d   = overrun_q;
    unique case (state_q)
      StIdle: begin
        // First frame after reset starts clearing without a swap.
        if (frame_start_in) begin
          color_d = clear_color_in;
          cnt_d   = '0;
        end
      end
      StClear: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q;
        wr_data_d = color_q;
        // Hold at the last address rather than wrapping.
        if (!clear_last) cnt_d = cnt_q + 16'd1;
        if (frame_start_in) overrun_d = 1'b1;
      end
      StRender: begin
        if (pix_fire) begin
          if (pix_in_range) begin
            wr_en_d   = 1'b1;
            wr_addr_d = pix_addr_in;
            wr_data_d = pix_color_in;
          end else begin
            // Accepted but dropped so the writer never stalls on a bad address.
            oob_d = 1'b1;
          end
        end
        if (frame_start_in) overrun_d = 1'b1;
      end
      StDone: begin
        if (frame_start_in) begin
          draw_bank_d = ~draw_bank_q;
          color_d     = clear_color_in;
          cnt_d       = '0;
        end
      end
      default: ;
    endcase
  end

  // Handshake and status decode from the state register only.
  always_comb begin
    pix_ready_out = 1'b0;
    busy_out      = 1'b0;
    unique case (state_q)
      StIdle:   ;
      StClear:  busy_out = 1'b1;
      StRender: begin
        pix_ready_out = 1'b1;
        busy_out      = 1'b1;
      end
      StDone:   ;
      default:  ;
    endcase
  end

  assign wr_en_out     = wr_en_q;
  assign wr_addr_out   = wr_addr_q;
  assign wr_data_out   = wr_data_q;
  assign wr_bank_out   = draw_bank_q;
  assign disp_bank_out = ~draw_bank_q;
  assign oob_out       = oob_q;
  assign overrun_out   = overrun_q;

endmodule
